// File: rtl/qei_pkg.sv
// Shared types for the quadrature encoder front end: step codes, FSM states and
// the Gray-phase helper used by the transition decoder.
package qei_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DN   = 2'd2,
        STEP_ERR  = 2'd3
    } step_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // {A,B} Gray code to phase index along the forward sequence 00->10->11->01.
    function automatic logic [1:0] phase_of(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    // Phase distance modulo 4: 1 is a forward step, 3 backward, 2 means both bits moved.
    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] d;
        step_e s;
        d = phase_of(cur_ab) - phase_of(prev_ab);
        case (d)
            2'd0:    s = STEP_NONE;
            2'd1:    s = STEP_UP;
            2'd2:    s = STEP_ERR;
            default: s = STEP_DN;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/qei_filter.sv
// One encoder pad: metastability flop chain followed by a stability filter that
// accepts a new level only after FILT_LEN consecutive differing synced samples.
module qei_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    // Any sample matching the current level restarts the run, so short pulses never land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (synced == level) begin
            cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
            cnt   <= '0;
            level <= synced;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qei_decoder.sv
// Quadrature encoder front end: filtered A/B/I pads, x4 decode into a signed
// position counter, index capture and illegal-transition accounting.
module qei_decoder
    import qei_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 qei_a,
    input  logic                 qei_b,
    input  logic                 qei_i,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 preset_we,
    input  logic [CNT_W-1:0]     preset_val,
    input  logic                 idx_zero_en,
    output logic [CNT_W-1:0]     position,
    output logic [CNT_W-1:0]     index_pos,
    output logic                 index_seen,
    output logic                 dir,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // INIT lasts one cycle past the filter fill time so prev is loaded from settled levels.
    localparam int INIT_CYC = SYNC_STAGES + FILT_LEN;
    localparam int IW       = $clog2(INIT_CYC + 1);

    logic          a_lvl, b_lvl, i_lvl;
    logic [1:0]    prev_ab;
    logic          i_prev;
    state_e        state, state_nxt;
    logic [IW-1:0] init_cnt, init_nxt;
    step_e         step;
    logic          run, idx_edge;
    logic [CNT_W-1:0] pos_nxt;

    qei_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(sys_clk), .rst_n(sys_rst_n), .pad(qei_a), .level(a_lvl));
    qei_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(sys_clk), .rst_n(sys_rst_n), .pad(qei_b), .level(b_lvl));
    qei_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_i (
        .clk(sys_clk), .rst_n(sys_rst_n), .pad(qei_i), .level(i_lvl));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init_nxt  = init_cnt;
        case (state)
            ST_INIT: begin
                init_nxt = init_cnt + 1'b1;
                if (init_cnt == IW'(INIT_CYC)) begin
                    state_nxt = ST_RUN;
                    init_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    assign run      = (state == ST_RUN);
    assign step     = run ? decode_step(prev_ab, {a_lvl, b_lvl}) : STEP_NONE;
    assign idx_edge = run & i_lvl & ~i_prev;

    always_comb begin
        pos_nxt = position;
        if (clr) begin
            pos_nxt = '0;
        end else if (preset_we) begin
            pos_nxt = preset_val;
        end else if (idx_zero_en && idx_edge) begin
            pos_nxt = '0;
        end else if (en && step == STEP_UP) begin
            pos_nxt = position + CNT_W'(1);
        end else if (en && step == STEP_DN) begin
            pos_nxt = position - CNT_W'(1);
        end
    end

    // prev/i_prev track the pins in both states; in INIT that is the initial load.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_ab    <= 2'b00;
            i_prev     <= 1'b0;
            position   <= '0;
            index_pos  <= '0;
            index_seen <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            prev_ab  <= {a_lvl, b_lvl};
            i_prev   <= i_lvl;
            position <= pos_nxt;
            err      <= (step == STEP_ERR);
            if (idx_edge) index_pos <= position;
            if (clr) begin
                index_seen <= 1'b0;
            end else if (idx_edge) begin
                index_seen <= 1'b1;
            end
            if (step == STEP_UP) begin
                dir <= 1'b1;
            end else if (step == STEP_DN) begin
                dir <= 1'b0;
            end
            if (clr) begin
                err_cnt <= '0;
            end else if (step == STEP_ERR && err_cnt != {ERR_CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule
